// File: rtl/adc_spi_seq.sv
// ADC serial-port sequencer: runs one 16-bit register write/read on the ADC
// SPI pins ({addr, data}, MSB first) or pulses the ADC hardware reset pin.
// Every ADC pin comes straight from a flop so the pins are glitch-free.
module adc_spi_seq #(
   parameter int unsigned pDIV     = 4,   // SCLK half-period in clk_usb cycles
   parameter int unsigned pRST_LEN = 16   // ADC_RESET pulse length in clk_usb cycles
) (
   input  logic       clk_usb,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       rw_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] wdata_i,
   input  logic       hwreset_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] rdata_o,
   output logic       ADC_SEN,
   output logic       ADC_SCLK,
   output logic       ADC_SDATA,
   output logic       ADC_RESET,
   input  logic       ADC_OVR_SDOUT
);

   typedef enum logic [2:0] {IDLE, RST, SETUP, SHIFT, HOLD, DONE} state_t;

   localparam logic [7:0] DIV_LAST = 8'(pDIV - 1);
   localparam logic [7:0] RST_LAST = 8'(pRST_LEN - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;     // cycles left in the current phase, minus one
   logic [3:0]  bit_q;     // index into the shift register, 15 down to 0
   logic        phase_q;   // 0 = SCLK high half, 1 = SCLK low half
   logic [15:0] sreg_q;
   logic        rw_q;
   logic [7:0]  cap_q;
   logic [7:0]  rdata_q;
   logic        sen_q, sclk_q, sdata_q, arst_q, busy_q, done_q;

   // Next bit to present; on reads the data half of the frame is driven low
   logic [3:0]  bit_d;
   logic        sdata_d;
   assign bit_d   = bit_q - 4'd1;
   assign sdata_d = (rw_q && !bit_d[3]) ? 1'b0 : sreg_q[bit_d];

   // Sequencer FSM; pin values are loaded on the transition into each state
   always_ff @(posedge clk_usb or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         sreg_q  <= '0;
         rw_q    <= 1'b0;
         cap_q   <= '0;
         rdata_q <= '0;
         sen_q   <= 1'b1;
         sclk_q  <= 1'b1;
         sdata_q <= 1'b0;
         arst_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // hardware reset has priority; nothing is queued behind it
               if (hwreset_i) begin
                  state_q <= RST;
                  cnt_q   <= RST_LAST;
                  arst_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end else if (start_i) begin
                  state_q <= SETUP;
                  cnt_q   <= DIV_LAST;
                  sreg_q  <= {addr_i, wdata_i};
                  rw_q    <= rw_i;
                  cap_q   <= '0;
                  sen_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            RST: begin
               if (cnt_q == 8'd0) begin
                  state_q <= DONE;
                  arst_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            SETUP: begin
               if (cnt_q == 8'd0) begin
                  state_q <= SHIFT;
                  phase_q <= 1'b0;
                  bit_q   <= 4'd15;
                  cnt_q   <= DIV_LAST;
                  sdata_q <= sreg_q[15];
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            SHIFT: begin
               if (cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end else if (!phase_q) begin
                  // falling edge: ADC latches the bit, SDATA stays put
                  phase_q <= 1'b1;
                  sclk_q  <= 1'b0;
                  cnt_q   <= DIV_LAST;
               end else begin
                  // last low cycle: capture readback on data bits only
                  if (rw_q && !bit_q[3]) cap_q <= {cap_q[6:0], ADC_OVR_SDOUT};
                  sclk_q  <= 1'b1;
                  phase_q <= 1'b0;
                  cnt_q   <= DIV_LAST;
                  if (bit_q == 4'd0) begin
                     state_q <= HOLD;
                     sdata_q <= 1'b0;
                  end else begin
                     bit_q   <= bit_d;
                     sdata_q <= sdata_d;
                  end
               end
            end
            HOLD: begin
               if (cnt_q == 8'd0) begin
                  state_q <= DONE;
                  sen_q   <= 1'b1;
                  done_q  <= 1'b1;
                  if (rw_q) rdata_q <= cap_q;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign rdata_o   = rdata_q;
   assign ADC_SEN   = sen_q;
   assign ADC_SCLK  = sclk_q;
   assign ADC_SDATA = sdata_q;
   assign ADC_RESET = arst_q;

endmodule

// File: tb/tb_adc_spi_seq.sv
// Randomized bench for adc_spi_seq: two instances (pDIV=4 and pDIV=1), each
// transaction checked against a frame-level model of the expected SPI frame.
module tb_adc_spi_seq;

   logic clk_usb = 1'b0;
   always #5 clk_usb = ~clk_usb;

   logic       rst = 1'b1, start = 1'b0, rw = 1'b0, hwr = 1'b0, sdout = 1'b0;
   logic       sel = 1'b0;   // 0 observes/drives the pDIV=4 instance, 1 the pDIV=1 one
   logic [7:0] addr = '0, wdata = '0;

   logic       busy4, done4, sen4, sclk4, sdat4, arst4;
   logic       busy1, done1, sen1, sclk1, sdat1, arst1;
   logic [7:0] rd4, rd1;

   adc_spi_seq #(.pDIV(4), .pRST_LEN(16)) u_dut4 (
      .clk_usb(clk_usb), .reset_i(rst), .start_i(start & ~sel), .rw_i(rw),
      .addr_i(addr), .wdata_i(wdata), .hwreset_i(hwr & ~sel),
      .busy_o(busy4), .done_o(done4), .rdata_o(rd4),
      .ADC_SEN(sen4), .ADC_SCLK(sclk4), .ADC_SDATA(sdat4), .ADC_RESET(arst4),
      .ADC_OVR_SDOUT(sdout));

   adc_spi_seq #(.pDIV(1), .pRST_LEN(3)) u_dut1 (
      .clk_usb(clk_usb), .reset_i(rst), .start_i(start & sel), .rw_i(rw),
      .addr_i(addr), .wdata_i(wdata), .hwreset_i(hwr & sel),
      .busy_o(busy1), .done_o(done1), .rdata_o(rd1),
      .ADC_SEN(sen1), .ADC_SCLK(sclk1), .ADC_SDATA(sdat1), .ADC_RESET(arst1),
      .ADC_OVR_SDOUT(sdout));

   logic       busy, done, sen, sclk, sdat, arst;
   logic [7:0] rdata;
   assign busy  = sel ? busy1 : busy4;
   assign done  = sel ? done1 : done4;
   assign sen   = sel ? sen1  : sen4;
   assign sclk  = sel ? sclk1 : sclk4;
   assign sdat  = sel ? sdat1 : sdat4;
   assign arst  = sel ? arst1 : arst4;
   assign rdata = sel ? rd1   : rd4;

   int         nvec = 0, nerr = 0;
   logic [7:0] rmodel [2];   // last read byte per instance

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One register transaction. inj_s >= 0: pulse start+hwreset with other
   // inputs at that cycle. inj_r >= 0: assert reset_i during the high half
   // of the bit following that many falling edges.
   task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] sd, input int inj_s, input int inj_r);
      int         div, rlen, nbusy, nfall, ndone, nchg, narst, lastf, badper;
      logic [15:0] pat, exp_pat;
      logic [7:0] rd_done;
      logic       psclk, psdat, aborted;
      div     = sel ? 1 : 4;
      exp_pat = {a, r ? 8'h00 : d};
      nbusy = 0; nfall = 0; ndone = 0; nchg = 0; narst = 0; lastf = 0; badper = 0;
      pat = '0; rd_done = '0; psclk = 1'b1; psdat = 1'b0; aborted = 1'b0;
      @(negedge clk_usb);
      rw = r; addr = a; wdata = d; start = 1'b1;
      for (int cyc = 0; cyc < 40 * div + 20; cyc++) begin
         @(negedge clk_usb);
         start = 1'b0; hwr = 1'b0; rw = r; addr = a;
         if (aborted) rst = 1'b0;
         if (busy) nbusy++;
         if (arst) narst++;
         if (done) begin ndone++; rd_done = rdata; end
         if (psclk && !sclk) begin
            if (nfall < 16) pat[15 - nfall] = sdat;
            if (nfall > 0 && cyc - lastf != 2 * div) badper++;
            lastf = cyc;
            nfall++;
            if (nfall >= 9 && nfall <= 16) sdout = sd[16 - nfall];
         end
         if (!psclk && !sclk && sdat !== psdat) nchg++;
         psclk = sclk; psdat = sdat;
         if (cyc == inj_s) begin start = 1'b1; hwr = 1'b1; addr = ~a; rw = ~r; end
         if (inj_r >= 0 && !aborted && nfall == inj_r && sclk) begin
            rst = 1'b1;
            #1;
            chk("rst_sen",  32'(sen),  32'd1);
            chk("rst_sclk", 32'(sclk), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_sdat", 32'(sdat), 32'd0);
            aborted = 1'b1;
            rmodel[0] = '0; rmodel[1] = '0;
         end
      end
      rlen = 0;
      if (aborted) begin
         chk("abort_done", 32'(ndone), 32'd0);
         chk("abort_rd",   32'(rdata), 32'(rmodel[sel]));
      end else begin
         if (r) rmodel[sel] = sd;
         chk("falls",   32'(nfall),   32'd16);
         chk("pattern", 32'(pat),     32'(exp_pat));
         chk("busy",    32'(nbusy),   32'(34 * div + 1));
         chk("done",    32'(ndone),   32'd1);
         chk("sclkper", 32'(badper),  32'(rlen));
         chk("sdat_lo", 32'(nchg),    32'd0);
         chk("no_arst", 32'(narst),   32'd0);
         chk("rdata",   32'(rd_done), 32'(rmodel[sel]));
      end
      chk("idle_sen", 32'(sen), 32'd1);
   endtask

   // Hardware reset pulse, optionally with a colliding start request.
   task automatic run_hwr(input logic with_start);
      int rlen, nbusy, narst, nsen, ndone;
      rlen = sel ? 3 : 16;
      nbusy = 0; narst = 0; nsen = 0; ndone = 0;
      @(negedge clk_usb);
      hwr = 1'b1; start = with_start; rw = 1'b0; addr = 8'h3C; wdata = 8'h5A;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk_usb);
         hwr = 1'b0; start = 1'b0;
         if (busy) nbusy++;
         if (arst) narst++;
         if (!sen) nsen++;
         if (done) ndone++;
      end
      chk("hwr_len",  32'(narst), 32'(rlen));
      chk("hwr_busy", 32'(nbusy), 32'(rlen + 1));
      chk("hwr_sen",  32'(nsen),  32'd0);
      chk("hwr_done", 32'(ndone), 32'd1);
      chk("hwr_rd",   32'(rdata), 32'(rmodel[sel]));
   endtask

   initial begin
      rmodel[0] = '0; rmodel[1] = '0;
      repeat (3) @(negedge clk_usb);
      #1;
      chk("r_sen4",  32'(sen4),  32'd1);
      chk("r_sclk4", 32'(sclk4), 32'd1);
      chk("r_sdat4", 32'(sdat4), 32'd0);
      chk("r_arst4", 32'(arst4), 32'd0);
      chk("r_busy4", 32'(busy4), 32'd0);
      chk("r_done4", 32'(done4), 32'd0);
      chk("r_rd4",   32'(rd4),   32'd0);
      chk("r_sen1",  32'(sen1),  32'd1);
      @(negedge clk_usb);
      rst = 1'b0;

      // pDIV = 4 instance
      sel = 1'b0;
      run_txn(1'b0, 8'h55, 8'hAA, 8'h00, -1, -1);
      run_txn(1'b1, 8'h0F, 8'h77, 8'hC3, -1, -1);
      run_hwr(1'b1);
      run_txn(1'b0, 8'h21, 8'h9D, 8'h00, 30, -1);
      run_txn(1'b1, 8'hA6, 8'h11, 8'h5E, -1, 8);
      run_txn(1'b1, 8'h3A, 8'h00, 8'h96, -1, -1);
      run_txn(1'b0, 8'h44, 8'h12, 8'hFF, -1, -1);   // write leaves rdata alone
      for (int k = 0; k < 6; k++)
         run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
      run_hwr(1'b0);

      // pDIV = 1 instance
      sel = 1'b1;
      run_txn(1'b0, 8'hFF, 8'hFF, 8'h00, -1, -1);
      run_txn(1'b1, 8'h80, 8'hFF, 8'h01, -1, -1);
      for (int k = 0; k < 6; k++)
         run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
      run_hwr(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
